pe_demux: RTL

PE_DEMUX -- requirements
Module: pe_demux

---
 rtl/pe_pkg.sv | 9 +
 rtl/pe_demux_lane.sv | 43 ++++
 rtl/pe_demux.sv | 66 ++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types for the pe_demux lane slices.
package pe_pkg;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/pe_demux_lane.sv
// One-entry register slice: holds a single word per output lane with push/pop/clear.
module pe_demux_lane
  import pe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  lane_state_t state;

  // A push wins over a pop in the same cycle so a streaming lane never bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LANE_EMPTY;
    end else if (clear) begin
      state <= LANE_EMPTY;
    end else if (push) begin
      state <= LANE_FULL;
    end else if (pop) begin
      state <= LANE_EMPTY;
    end
  end

  // Data is only written on a push, so an emptied lane keeps showing its last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (push && !clear) begin
      data <= push_data;
    end
  end

  assign valid = (state == LANE_FULL);

endmodule

// File: rtl/pe_demux.sv
// Demultiplexes one valid/ready stream onto N one-entry lanes, by select or round-robin.
module pe_demux
  import pe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [SEL_WIDTH-1:0]        in_sel,
  input  logic                        auto_mode,
  input  logic                        clear,
  output logic [(1<<SEL_WIDTH)-1:0]   out_valid,
  input  logic [(1<<SEL_WIDTH)-1:0]   out_ready,
  output logic [WIDTH-1:0]            out_data [(1<<SEL_WIDTH)-1:0],
  output logic [SEL_WIDTH-1:0]        ptr,
  output logic                        wrap
);

  localparam int N = 1 << SEL_WIDTH;
  localparam logic [SEL_WIDTH-1:0] PTR_LAST = SEL_WIDTH'(N - 1);

  logic [SEL_WIDTH-1:0] target;
  logic                 accept;

  // A full lane can still take a word when its consumer drains it in the same cycle.
  assign target   = auto_mode ? ptr : in_sel;
  assign in_ready = !clear && (!out_valid[target] || out_ready[target]);
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    pe_demux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .push     (accept && (target == SEL_WIDTH'(i))),
      .pop      (out_ready[i]),
      .push_data(in_data),
      .valid    (out_valid[i]),
      .data     (out_data[i])
    );
  end

  // Pointer only advances on accepted words in auto mode; wrap flags the N-1 -> 0 step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (clear) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (accept && auto_mode) begin
        ptr  <= ptr + SEL_WIDTH'(1);
        wrap <= (ptr == PTR_LAST);
      end
    end
  end

endmodule
